dmem_scan_reader: RTL and testbench

//  Read-side companion to the pipelined CPU's data-memory writes. Walks a window of data memory
//  (base..last) one word per step, on the memory's read-only port, and holds the fetched word and
//  its address for the 7-segment/VGA path.
//  - Manual mode: one address per debounced button step; the current word is re-read every DWELL cycles.
//  - Auto mode: advances every DWELL cycles.
//  - Never issues a read while the CPU is writing.

---
 rtl/dmem_scan_reader_if.sv | 26 ++
 rtl/dmem_scan_reader.sv | 149 ++++++++++++++
 tb/tb_dmem_scan_reader.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_scan_reader_if.sv
// Read-only data-memory port shared by the scan reader (master) and the data memory (slave).
// Latency: rd_data is valid RD_LAT cycles after an rd_en strobe; the interface adds none.
// Backpressure: mem_busy from the memory side blocks new read strobes while the CPU writes.
interface dmem_scan_reader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              mem_busy;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    input  mem_busy
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    output mem_busy
  );
endinterface

// File: rtl/dmem_scan_reader.sv
// Walks a data-memory window base..last one word per step and holds the word for display.
// Latency: step edge -> rd_en next cycle (if not busy) -> disp update RD_LAT+1 cycles after rd_en.
// Backpressure: mem_busy holds the read in ISSUE; step edges arriving outside SHOW are dropped.
module dmem_scan_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DWELL  = 10000000,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                step,
  input  logic                auto,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   last_addr,
  dmem_scan_reader_if.master  mem,
  output logic [DATA_W-1:0]   disp_word,
  output logic [ADDR_W-1:0]   disp_addr,
  output logic                disp_valid,
  output logic                wrap
);

  // One counter serves both the read-latency wait and the dwell interval.
  localparam int CNT_W = ($clog2(DWELL) > 2) ? $clog2(DWELL) : 2;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    SHOW  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] cur;
  logic              step_q;
  logic              step_rise;
  logic              dwell_done;
  logic              wrap_hit;
  logic              rd_go;
  logic              capture;
  logic              advance;

  assign step_rise  = step & ~step_q;
  assign dwell_done = (cnt == DWELL_LAST);
  // A window with base above last degenerates to the single word at base.
  assign wrap_hit   = (cur == last_addr) || (base_addr > last_addr);

  assign mem.rd_en   = rd_go;
  assign mem.rd_addr = cur;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode plus the read strobe, capture and advance controls.
  always_comb begin
    state_n = state;
    rd_go   = 1'b0;
    capture = 1'b0;
    advance = 1'b0;
    case (state)
      INIT: begin
        state_n = ISSUE;
      end
      ISSUE: begin
        if (!mem.mem_busy) begin
          rd_go   = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (cnt == LAT_LAST) begin
          capture = 1'b1;
          state_n = SHOW;
        end
      end
      SHOW: begin
        // Step and dwell expiry together still give a single advance.
        if (step_rise || (auto && dwell_done)) begin
          advance = 1'b1;
          state_n = ISSUE;
        end else if (!auto && dwell_done) begin
          state_n = ISSUE;
        end
      end
      default: begin
        state_n = INIT;
      end
    endcase
  end

  // Shared counter: cleared on every state change, counts while waiting or showing.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (state_n != state) begin
      cnt <= '0;
    end else if (state == WAIT || state == SHOW) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Step edge history is kept in every state so edges outside SHOW are simply lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  // Scan address: loaded from base on entry, moved only on an advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= advance && wrap_hit;
      if (state == INIT) begin
        cur <= base_addr;
      end else if (advance) begin
        cur <= wrap_hit ? base_addr : cur + ADDR_W'(1);
      end
    end
  end

  // Display registers hold the last captured word until the next capture or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_word  <= '0;
      disp_addr  <= '0;
      disp_valid <= 1'b0;
    end else if (capture) begin
      disp_word  <= mem.rd_data;
      disp_addr  <= cur;
      disp_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_scan_reader.sv
// Scoreboard bench for dmem_scan_reader: randomized steps, auto/refresh dwells, busy windows and resets.
// Expected reads (address, wrap, issue cycle) are queued by the stimulus; a negedge monitor checks them.
// The memory model returns junk except exactly RD_LAT cycles after a read strobe.
module tb_dmem_scan_reader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DWELL  = 4;
  localparam int RD_LAT = 2;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    bit                wrap;
    int                cyc;
  } rd_exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              step = 1'b0;
  logic              auto = 1'b0;
  logic [ADDR_W-1:0] base_addr = 8'h10;
  logic [ADDR_W-1:0] last_addr = 8'h12;
  logic [DATA_W-1:0] disp_word;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic              wrap;

  dmem_scan_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  dmem_scan_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DWELL(DWELL), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset), .step(step), .auto(auto),
    .base_addr(base_addr), .last_addr(last_addr), .mem(mem_if),
    .disp_word(disp_word), .disp_addr(disp_addr), .disp_valid(disp_valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  // Data memory model with a two-stage read pipeline; invalid slots return a junk pattern.
  logic [DATA_W-1:0] mem [256];
  logic              p1_v = 1'b0, p2_v = 1'b0;
  logic [DATA_W-1:0] p1_d = '0, p2_d = '0;
  always @(posedge clk) begin
    p1_v <= mem_if.rd_en;
    p1_d <= mem[mem_if.rd_addr];
    p2_v <= p1_v;
    p2_d <= p1_d;
  end
  assign mem_if.rd_data = p2_v ? p2_d : 16'hDEAD;

  int                nchk = 0;
  int                nerr = 0;
  rd_exp_t           expq[$];
  logic [ADDR_W-1:0] model_cur;
  int                show_cyc = -1;

  // Monitor state.
  logic [DATA_W-1:0] exp_word = '0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic              exp_valid = 1'b0;
  bit                cap_pend = 0;
  int                cap_at = 0;
  logic [DATA_W-1:0] cap_word = '0;
  logic [ADDR_W-1:0] cap_addr = '0;
  int                wrap_seen = 0;
  rd_exp_t           mon_e;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (rst_seen) begin
        nchk++;
        if (mem_if.rd_en !== 1'b0 || wrap !== 1'b0 || disp_word !== '0 ||
            disp_addr !== '0 || disp_valid !== 1'b0) begin
          nerr++;
          $display("FAIL reset_outputs cyc=%0d: got rd_en=%b wrap=%b word=%h addr=%h valid=%b, need all 0",
                   cyc, mem_if.rd_en, wrap, disp_word, disp_addr, disp_valid);
        end
        exp_word = '0; exp_addr = '0; exp_valid = 1'b0;
        cap_pend = 0; wrap_seen = 0; show_cyc = -1;
      end else begin
        if (wrap === 1'b1) wrap_seen++;
        if (cap_pend && cyc == cap_at) begin
          exp_word  = cap_word;
          exp_addr  = cap_addr;
          exp_valid = 1'b1;
          cap_pend  = 0;
        end
        nchk++;
        if (disp_word !== exp_word || disp_addr !== exp_addr || disp_valid !== exp_valid) begin
          nerr++;
          $display("FAIL display cyc=%0d: got word=%h addr=%h valid=%b, need word=%h addr=%h valid=%b",
                   cyc, disp_word, disp_addr, disp_valid, exp_word, exp_addr, exp_valid);
        end
        if (mem_if.rd_en !== 1'b0) begin
          if (expq.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL unexpected_read cyc=%0d: got rd_en=%b addr=%h, need no read", cyc, mem_if.rd_en, mem_if.rd_addr);
          end else begin
            mon_e = expq.pop_front();
            nchk++;
            if (mem_if.rd_en !== 1'b1 || mem_if.rd_addr !== mon_e.addr || mem_if.mem_busy !== 1'b0) begin
              nerr++;
              $display("FAIL read_addr cyc=%0d: got rd_en=%b addr=%h busy=%b, need rd_en=1 addr=%h busy=0",
                       cyc, mem_if.rd_en, mem_if.rd_addr, mem_if.mem_busy, mon_e.addr);
            end
            nchk++;
            if (cyc != mon_e.cyc) begin
              nerr++;
              $display("FAIL read_cycle: got read at cycle %0d, need cycle %0d", cyc, mon_e.cyc);
            end
            nchk++;
            if (wrap_seen != (mon_e.wrap ? 1 : 0)) begin
              nerr++;
              $display("FAIL wrap_pulses cyc=%0d: got %0d wrap pulses before read of %h, need %0d",
                       cyc, wrap_seen, mon_e.addr, mon_e.wrap ? 1 : 0);
            end
            cap_pend = 1;
            cap_at   = cyc + RD_LAT + 1;
            cap_addr = mon_e.addr;
            cap_word = mem[mon_e.addr];
            show_cyc = cap_at;
          end
          wrap_seen = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Block until the cycle the display is due to update (first SHOW cycle), bounded.
  task automatic wait_show(output bit timed_out);
    int n;
    n = 0;
    timed_out = 0;
    while (!(show_cyc == cyc) && n < 200) begin
      tick();
      n++;
    end
    if (show_cyc != cyc) begin
      nchk++; nerr++;
      $display("FAIL capture_timeout: no display update within %0d cycles, need one", n);
      timed_out = 1;
    end
  endtask

  // Reference advance rule: wrap to base at the window end or for a degenerate window.
  function automatic void model_adv(output logic [ADDR_W-1:0] a, output bit w);
    if (model_cur == last_addr || base_addr > last_addr) begin
      a = base_addr;
      w = 1;
    end else begin
      a = model_cur + 8'd1;
      w = 0;
    end
  endfunction

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  initial begin
    logic [ADDR_W-1:0] a;
    bit  w, abort, stepm;
    int  mode, b, k, off, len, auto_v;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i + 'h100);
    mem_if.mem_busy = 1'b0;
    abort = 0;
    repeat (3) tick();
    reset = 1'b0;
    model_cur = base_addr;
    expq.push_back('{base_addr, 1'b0, cyc + 1});
    wait_show(abort);

    for (int it = 0; it < 70 && !abort; it++) begin
      if (it == 40) begin
        // Reset while the read launched by a step is still in WAIT.
        auto = 1'b0;
        model_adv(a, w);
        expq.push_back('{a, w, cyc + 1});
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_cur = base_addr;
        expq.push_back('{base_addr, 1'b0, cyc + 1});
        wait_show(abort);
        continue;
      end

      mode   = $urandom_range(0, 3);
      b      = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      k      = $urandom_range(0, DWELL - 1);
      auto_v = $urandom_range(0, 1);
      if (it < 3) begin
        mode = 2; b = 0; auto_v = 0;
      end else if (it == 3) begin
        mode = 2; k = 0; b = 5; auto_v = 0;
      end else if (it < 7) begin
        mode = 1; b = 0;
        if (it == 4) begin
          base_addr = 8'hFE;
          last_addr = 8'h01;
        end
      end else if (it == 7) begin
        mode = 0; b = 0;
        mem[model_cur] = 16'hBEEF;
      end else begin
        if ($urandom_range(0, 5) == 0) begin
          base_addr = 8'($urandom);
          last_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                                  : base_addr + 8'($urandom_range(0, 4));
        end
        if ($urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 1) == 1) mem[model_cur] = 16'($urandom);
          else mem[8'($urandom)] = 16'($urandom);
        end
      end

      stepm = (mode >= 2);
      if (mode == 0) begin
        auto = 1'b0; a = model_cur; w = 0; off = DWELL;
      end else if (mode == 1) begin
        auto = 1'b1; model_adv(a, w); off = DWELL;
      end else begin
        auto = auto_v[0]; model_adv(a, w); off = k + 1;
      end
      model_cur = a;
      expq.push_back('{a, w, cyc + imax(off, b)});

      // Second step pulse lands while the read is in flight and must be ignored.
      len = stepm ? imax(b, k + 4) : imax(b, 1);
      for (int c = 0; c < len; c++) begin
        mem_if.mem_busy = (c < b);
        step = stepm && (c == k || c == k + 2);
        tick();
      end
      mem_if.mem_busy = 1'b0;
      step = 1'b0;
      wait_show(abort);
    end

    nchk++;
    if (expq.size() != 0) begin
      nerr++;
      $display("FAIL pending_reads: got %0d expected reads never issued, need 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #500000;
    nerr++;
    $display("FAIL watchdog: simulation still running at time %0t, need completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $fatal(1, "watchdog expired");
  end

endmodule
